// File: rtl/line_echo_ctrl.sv
// Line buffer between UART RX and TX: stores bytes until TERM, then replays the line plus CR LF.
// Latency: byte stored 2 cycles after RX_status rises; first TX_en 2 cycles after the terminator rises.
// Backpressure: each TX_en waits for TX_status idle; bytes arriving while busy or with a full buffer are dropped and flagged.
module line_echo_ctrl #(
  parameter int         DEPTH = 16,
  parameter int         AW    = 4,
  parameter logic [7:0] TERM  = 8'h0D
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          upcase,
  input  logic [7:0]    RX_data,
  input  logic          RX_status,
  input  logic          TX_status,
  output logic [7:0]    TX_data,
  output logic          TX_en,
  output logic          busy,
  output logic          overflow,
  output logic [AW:0]   line_len
);

  typedef enum logic [2:0] {COLLECT, ISSUE, WAIT_BUSY, WAIT_DONE, NEXT} state_t;
  typedef enum logic [1:0] {PH_LINE, PH_CR, PH_LF} phase_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  phase_t        phase;
  logic          rs_q, ev_q;
  logic [7:0]    byte_q;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    wb_cnt;
  logic [7:0]    tx_hold;
  logic [7:0]    mem [DEPTH];

  logic [7:0]    cur_byte, fold_byte;
  logic          col_ev, is_term, do_store, do_drop, last_line;
  logic [AW:0]   rd_nxt;

  assign col_ev    = ev_q && (state == COLLECT);
  assign is_term   = col_ev && (byte_q == TERM);
  assign do_store  = col_ev && (byte_q != TERM) && (count < FULL);
  assign do_drop   = col_ev && (byte_q != TERM) && (count >= FULL);
  assign rd_nxt    = {1'b0, rd_ptr} + (AW+1)'(1);
  assign last_line = (rd_nxt >= count);
  assign fold_byte = (upcase && byte_q >= 8'h61 && byte_q <= 8'h7A) ? byte_q - 8'h20 : byte_q;
  assign line_len  = count;

  always_comb begin
    case (phase)
      PH_LINE: cur_byte = mem[rd_ptr];
      PH_CR:   cur_byte = 8'h0D;
      PH_LF:   cur_byte = 8'h0A;
      default: cur_byte = 8'h00;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) state <= COLLECT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    TX_en     = 1'b0;
    case (state)
      COLLECT:   if (is_term) state_nxt = ISSUE;
      ISSUE: begin
        // Hold the strobe back until the sender reports idle.
        if (TX_status) begin
          TX_en     = 1'b1;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: if (!TX_status || wb_cnt == 2'd3) state_nxt = WAIT_DONE;
      WAIT_DONE: if (TX_status) state_nxt = NEXT;
      NEXT:      state_nxt = (phase == PH_LF) ? COLLECT : ISSUE;
      default:   state_nxt = COLLECT;
    endcase
    TX_data = (state == ISSUE) ? cur_byte : tx_hold;
    busy    = (state != COLLECT);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      // Track the live level so a byte overlapping reset is not replayed afterwards.
      rs_q     <= RX_status;
      ev_q     <= 1'b0;
      byte_q   <= 8'h00;
      count    <= '0;
      rd_ptr   <= '0;
      phase    <= PH_LINE;
      wb_cnt   <= 2'd0;
      tx_hold  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      rs_q <= RX_status;
      ev_q <= RX_status & ~rs_q;
      if (RX_status && !rs_q) byte_q <= RX_data;

      if (ev_q && state != COLLECT) overflow <= 1'b1;
      else if (do_store) begin
        count <= count + (AW+1)'(1);
        if (count == '0) overflow <= 1'b0;
      end else if (do_drop) overflow <= 1'b1;

      if (is_term) begin
        rd_ptr <= '0;
        phase  <= (count == '0) ? PH_CR : PH_LINE;
      end

      case (state)
        ISSUE: begin
          wb_cnt <= 2'd0;
          if (TX_status) tx_hold <= cur_byte;
        end
        WAIT_BUSY: wb_cnt <= wb_cnt + 2'd1;
        NEXT: begin
          case (phase)
            PH_LINE: begin
              if (!last_line) rd_ptr <= rd_ptr + AW'(1);
              else            phase  <= PH_CR;
            end
            PH_CR: phase <= PH_LF;
            default: begin
              count <= '0;
              phase <= PH_LINE;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_store) mem[count[AW-1:0]] <= fold_byte;
  end

endmodule

// File: tb/tb_line_echo_ctrl.sv
// Directed bench for line_echo_ctrl with a simple sender model that goes busy after each load.
module tb_line_echo_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       upcase = 1'b0;
  logic [7:0] RX_data = 8'h00;
  logic       RX_status = 1'b0;
  logic       TX_status = 1'b1;
  logic [7:0] TX_data;
  logic       TX_en;
  logic       busy;
  logic       overflow;
  logic [4:0] line_len;

  line_echo_ctrl #(.DEPTH(16), .AW(4), .TERM(8'h0D)) dut (
    .sys_clk  (clk),
    .reset    (reset),
    .upcase   (upcase),
    .RX_data  (RX_data),
    .RX_status(RX_status),
    .TX_status(TX_status),
    .TX_data  (TX_data),
    .TX_en    (TX_en),
    .busy     (busy),
    .overflow (overflow),
    .line_len (line_len)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  int         n_total = 0;
  int         busy_time = 3;
  int         busy_left = 0;
  int         viol = 0;
  int         rx_cyc = 0;
  logic       en_prev = 1'b0;
  logic [7:0] tx_log [$];
  int         tx_cyc [$];
  logic [7:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Sender: goes busy for busy_time cycles after each load; busy_time 0 never drops TX_status.
  always @(negedge clk) begin
    if (TX_en) begin
      tx_log.push_back(TX_data);
      tx_cyc.push_back(cyc);
      if (!TX_status || en_prev) viol++;
      if (busy_time > 0) begin
        TX_status = 1'b0;
        busy_left = busy_time;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) TX_status = 1'b1;
    end
    en_prev = TX_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_data   = b;
    RX_status = 1'b1;
    rx_cyc    = cyc;
    tick();
    tick();
    RX_status = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_tx(input string tag, input int n, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (tx_log.size() >= n && !busy) break;
      tick();
    end
    check({tag, "_done"}, 32'((tx_log.size() >= n) && !busy), 32'd1);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_count"}, tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(tx_log[i]), 32'(exp_q[i]));
  endtask

  task automatic clear_log();
    tx_log.delete();
    tx_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    tick(); tick(); tick();
    check("rst_tx_en", 32'(TX_en), 32'd0);
    check("rst_tx_data", 32'(TX_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_line_len", 32'(line_len), 32'd0);
    reset = 1'b0;
    tick();

    // Plain line "ab", including store and terminator latency.
    clear_log();
    RX_data = 8'h61; RX_status = 1'b1;
    tick();
    check("store_lat1", 32'(line_len), 32'd0);
    tick();
    check("store_lat2", 32'(line_len), 32'd1);
    RX_status = 1'b0;
    tick(); tick();
    send_byte(8'h62);
    send_byte(8'h0D);
    check("a_busy", 32'(busy), 32'd1);
    check("a_line_len", 32'(line_len), 32'd2);
    check("a_term_lat", 32'(tx_cyc.size() > 0 ? tx_cyc[0] - rx_cyc : -1), 32'd2);
    wait_tx("a", 4, 300);
    exp_q = '{8'h61, 8'h62, 8'h0D, 8'h0A};
    check_log("a");
    check("a_len_after", 32'(line_len), 32'd0);

    // Case folding, including both ends of the lowercase range.
    clear_log();
    upcase = 1'b1;
    send_byte(8'h61); send_byte(8'h5A); send_byte(8'h7B); send_byte(8'h60); send_byte(8'h7A);
    send_byte(8'h0D);
    wait_tx("up", 7, 400);
    exp_q = '{8'h41, 8'h5A, 8'h7B, 8'h60, 8'h5A, 8'h0D, 8'h0A};
    check_log("up");
    upcase = 1'b0;

    // Fill to capacity, then overflow.
    clear_log();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i));
    check("full_ovf", 32'(overflow), 32'd0);
    check("full_len", 32'(line_len), 32'd16);
    for (int i = 16; i < 20; i++) send_byte(8'(8'h30 + i));
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_len", 32'(line_len), 32'd16);
    send_byte(8'h0D);
    wait_tx("ovf", 18, 800);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h30 + i));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    check_log("ovf");
    check("ovf_sticky", 32'(overflow), 32'd1);
    clear_log();
    send_byte(8'h71);
    check("ovf_clear", 32'(overflow), 32'd0);
    check("ovf_next_len", 32'(line_len), 32'd1);
    send_byte(8'h0D);
    wait_tx("q", 3, 300);
    exp_q = '{8'h71, 8'h0D, 8'h0A};
    check_log("q");

    // Empty line.
    clear_log();
    send_byte(8'h0D);
    check("empty_busy", 32'(busy), 32'd1);
    check("empty_len", 32'(line_len), 32'd0);
    wait_tx("empty", 2, 300);
    exp_q = '{8'h0D, 8'h0A};
    check_log("empty");

    // Slow sender and a byte arriving mid-transmission.
    clear_log();
    busy_time = 100;
    send_byte(8'h68); send_byte(8'h69); send_byte(8'h0D);
    send_byte(8'h7A);
    check("mid_ovf", 32'(overflow), 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    wait_tx("mid", 4, 1500);
    exp_q = '{8'h68, 8'h69, 8'h0D, 8'h0A};
    check_log("mid");

    // Sender that never reports busy: load timeout paces the bytes.
    clear_log();
    busy_time = 0;
    send_byte(8'h6B); send_byte(8'h0D);
    wait_tx("nobusy", 3, 300);
    exp_q = '{8'h6B, 8'h0D, 8'h0A};
    check_log("nobusy");
    check("nobusy_gap", 32'(tx_cyc.size() > 1 ? tx_cyc[1] - tx_cyc[0] : -1), 32'd7);
    busy_time = 3;

    // Reset during the second line byte.
    clear_log();
    send_byte(8'h6D); send_byte(8'h6E); send_byte(8'h0D);
    for (int i = 0; i < 200; i++) begin
      if (tx_log.size() >= 2) break;
      tick();
    end
    check("rst_mid_seen", 32'(tx_log.size()), 32'd2);
    reset = 1'b1;
    tick();
    check("rst_mid_tx_en", 32'(TX_en), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_len", 32'(line_len), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("rst_no_crlf", 32'(tx_log.size()), 32'd2);
    clear_log();
    send_byte(8'h78); send_byte(8'h0D);
    wait_tx("x", 3, 300);
    exp_q = '{8'h78, 8'h0D, 8'h0A};
    check_log("x");

    check("tx_protocol", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
